// File: rtl/strobe_period_meter.sv
// -----------------------------------------------------------------------------
// strobe_period_meter
//
// Measures the number of clk cycles between successive single-cycle strobes
// and presents each measured period on a valid/ready output. Also reports
// sticky overrun and timeout flags and a period-lock indication.
//
// Ports:
//   clk           in   1      system clock, all logic on posedge
//   reset_n       in   1      synchronous, active-low reset
//   strobe_in     in   1      one-cycle event pulse from the upstream strobe stage
//   clear         in   1      synchronous soft restart; wins over strobe_in
//   period_out    out  WIDTH  last captured period in clk cycles
//   period_valid  out  1      period_out holds an untransferred value
//   period_ready  in   1      consumer accepts; transfer on valid & ready
//   overrun       out  1      sticky: an unread period was overwritten
//   timeout       out  1      sticky: counter saturated with no strobe
//   locked        out  1      LOCK_COUNT consecutive periods within TOL of predecessor
// -----------------------------------------------------------------------------
module strobe_period_meter #(
  parameter int WIDTH      = 20,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe_in,
  input  logic             clear,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overrun,
  output logic             timeout,
  output logic             locked
);

  typedef enum logic {
    IDLE = 1'b0,   // no reference strobe seen yet
    MEAS = 1'b1    // counting cycles since the last strobe
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] TOL_W    = WIDTH'(TOL);
  localparam logic [7:0]       LOCK_MAX = 8'(LOCK_COUNT);

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] prev_period;
  logic             have_prev;     // a period has been captured since leaving IDLE
  logic [7:0]       match_cnt;

  logic             start;         // first strobe: begins the reference interval
  logic             capture;       // strobe while measuring: cnt is a period
  logic             saturate;      // counter hit its maximum with no strobe

  logic [WIDTH-1:0] diff;
  logic             is_match;
  logic [7:0]       match_next;

  // ---------------------------------------------------------------------------
  // Next-state and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave a value held and infer a latch.
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    saturate   = 1'b0;

    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (strobe_in) begin
            start      = 1'b1;
            state_next = MEAS;
          end
        end
        MEAS: begin
          if (strobe_in) begin
            // A strobe in the saturation cycle still counts as a capture.
            capture = 1'b1;
          end else if (cnt == CNT_MAX) begin
            saturate   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Lock comparison: unsigned absolute difference, no wrap-around
  // ---------------------------------------------------------------------------
  always_comb begin
    diff       = (cnt >= prev_period) ? (cnt - prev_period) : (prev_period - cnt);
    is_match   = (diff <= TOL_W);
    match_next = 8'd0;
    if (is_match) begin
      match_next = (match_cnt == LOCK_MAX) ? match_cnt : (match_cnt + 8'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter, output handshake, sticky flags and lock tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt          <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
      match_cnt    <= 8'd0;
      prev_period  <= '0;
      have_prev    <= 1'b0;
    end else if (clear) begin
      // Soft restart: everything except the last reported period.
      cnt          <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
      match_cnt    <= 8'd0;
      prev_period  <= '0;
      have_prev    <= 1'b0;
    end else begin
      // A strobe at cycle t makes cnt read 1 during t+1, so the value seen
      // at the next strobe is exactly the cycle distance between the two.
      if (start || capture) begin
        cnt <= WIDTH'(1);
      end else if (saturate) begin
        cnt <= '0;
      end else if (state == MEAS) begin
        cnt <= cnt + WIDTH'(1);
      end

      if (capture) begin
        period_out   <= cnt;
        period_valid <= 1'b1;
        if (period_valid && !period_ready) begin
          overrun <= 1'b1;
        end
        prev_period <= cnt;
        have_prev   <= 1'b1;
        // The first period after IDLE has no predecessor; it only seeds prev.
        if (have_prev) begin
          match_cnt <= match_next;
          locked    <= (match_next == LOCK_MAX);
        end
      end else if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end

      if (saturate) begin
        timeout   <= 1'b1;
        match_cnt <= 8'd0;
        locked    <= 1'b0;
        have_prev <= 1'b0;
      end
    end
  end

endmodule
